// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element tables
// for the RAM built-in self-test block.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_e;

    // Background bit, replicated across the word
    localparam logic B0 = 1'b0;
    localparam logic B1 = 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic el_desc(elem_e e);
        return (e == M3) || (e == M4);
    endfunction

    function automatic logic el_has_read(elem_e e);
        return e != M0;
    endfunction

    function automatic logic el_has_write(elem_e e);
        return e != M5;
    endfunction

    function automatic logic el_rbg(elem_e e);
        logic b;
        case (e)
            M2, M4:  b = B1;
            default: b = B0;
        endcase
        return b;
    endfunction

    function automatic logic el_wbg(elem_e e);
        logic b;
        case (e)
            M1, M3:  b = B1;
            default: b = B0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the March
// elements, with end-of-element flag.
module ram_bist_addr_gen #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              adv,
    input  logic              desc,
    input  logic              next_desc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] TOP =
        ADDR_W'(DEPTH - 1);

    assign last = desc ? (addr == '0)
                       : (addr == TOP);

    // Step within an element; jump to the next
    // element's start address at its boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (init) begin
            addr <= '0;
        end else if (adv) begin
            if (last)
                addr <= next_desc ? TOP : '0;
            else if (desc)
                addr <= addr - 1'b1;
            else
                addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/ram_march_bist.sv
// March C- self-test sequencer for the
// 16x16 synchronous RAM port.
import ram_bist_pkg::*;

module ram_march_bist #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] fail_expect,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        st;
    elem_e             elem;
    logic              ph;
    logic [ADDR_W-1:0] addr;
    logic              last;

    logic              has_rd;
    logic              slot_end;
    logic              cmp_now;
    logic [DATA_W-1:0] rexp;
    logic              mism;
    logic              fin;
    logic              accept;
    logic              adv;
    logic              cur_desc;
    elem_e             nxt_elem;
    logic              nxt_ph;
    logic              nxt_we;
    logic              nxt_desc;
    logic [DATA_W-1:0] nxt_wd;

    // Current slot decode and next command
    always_comb begin
        has_rd   = el_has_read(elem);
        slot_end = !has_rd || ph;
        cmp_now  = (st == S_RUN) && has_rd && ph;
        rexp     = {DATA_W{el_rbg(elem)}};
        mism     = cmp_now && (mem_rdata != rexp);
        fin      = slot_end && last && (elem == M5);
        accept   = start && (st != S_RUN);
        adv      = (st == S_RUN) && !mism
                   && slot_end && !fin;
        cur_desc = el_desc(elem);
        nxt_elem = (slot_end && last)
                   ? elem_e'(elem + 3'd1) : elem;
        nxt_ph   = !slot_end;
        nxt_we   = nxt_ph ? el_has_write(nxt_elem)
                          : !el_has_read(nxt_elem);
        nxt_desc = el_desc(nxt_elem);
        nxt_wd   = {DATA_W{el_wbg(nxt_elem)}};
    end

    ram_bist_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (accept),
        .adv       (adv),
        .desc      (cur_desc),
        .next_desc (nxt_desc),
        .addr      (addr),
        .last      (last)
    );

    assign mem_addr = addr;

    // Control FSM, compare and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_IDLE;
            elem        <= M0;
            ph          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            fail_expect <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
        end else if (accept) begin
            st          <= S_RUN;
            elem        <= M0;
            ph          <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            fail_expect <= '0;
            mem_we      <= 1'b1;
            mem_wdata   <= {DATA_W{B0}};
        end else if (st == S_RUN) begin
            if (mism) begin
                st          <= S_DONE;
                busy        <= 1'b0;
                done        <= 1'b1;
                pass        <= 1'b0;
                fail_addr   <= addr;
                fail_data   <= mem_rdata;
                fail_expect <= rexp;
                mem_we      <= 1'b0;
            end else if (fin) begin
                st     <= S_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                pass   <= 1'b1;
                mem_we <= 1'b0;
            end else begin
                elem      <= nxt_elem;
                ph        <= nxt_ph;
                mem_we    <= nxt_we;
                mem_wdata <= nxt_wd;
            end
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist with a faultable
// RAM model and a behavioural March model.
module tb_ram_march_bist;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [3:0]  fail_addr;
    logic [15:0] fail_data, fail_expect;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;

    int checks = 0;
    int passed = 0;

    int          f1a = -1;
    logic [15:0] f1m = 16'h0;
    int          f0a = -1;
    logic [15:0] f0m = 16'h0;

    logic [15:0] ram [16];

    logic        e_we   [200];
    logic [3:0]  e_addr [200];
    logic [15:0] e_wd   [200];
    int          exp_n;
    bit          m_pass;
    int          m_edge;
    int          m_addr;
    logic [15:0] m_data, m_exp;

    ram_march_bist dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data),
        .fail_expect (fail_expect),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] flt(
        int a, logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (a == f1a) r = r | f1m;
        if (a == f0a) r = r & ~f0m;
        return r;
    endfunction

    // RAM with stuck-at cells
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= flt(int'(mem_addr),
                                 mem_wdata);
        else
            mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h want %0h",
                      nm, got, exp);
    endtask

    task automatic put(input int e, input logic we,
                       input int a,
                       input logic [15:0] wd);
        e_we[e]   = we;
        e_addr[e] = 4'(a);
        e_wd[e]   = wd;
    endtask

    // Walks March C- over an array memory
    task automatic build();
        logic [15:0] m [16];
        logic [15:0] v, ex, wv;
        int e;
        e = 0;
        m_pass = 1; m_addr = 0;
        m_data = 0; m_exp = 0;
        for (int el = 0; el < 6; el++) begin
            for (int i = 0; i < 16; i++) begin
                int a;
                a = (el == 3 || el == 4) ? 15 - i : i;
                if (el == 0) begin
                    put(e, 1'b1, a, 16'h0);
                    m[a] = flt(a, 16'h0);
                    e++;
                end else begin
                    v  = m[a];
                    ex = (el == 2 || el == 4)
                         ? 16'hFFFF : 16'h0000;
                    wv = (el == 1 || el == 3)
                         ? 16'hFFFF : 16'h0000;
                    put(e, 1'b0, a, 16'h0);
                    e++;
                    put(e, el != 5, a, wv);
                    if (v != ex) begin
                        m_pass = 0;
                        m_edge = e + 1;
                        m_addr = a;
                        m_data = v;
                        m_exp  = ex;
                        exp_n  = e + 1;
                        return;
                    end
                    if (el != 5) m[a] = flt(a, wv);
                    e++;
                end
            end
        end
        exp_n  = e;
        m_edge = e;
    endtask

    task automatic tr_cmp(input int e, inout int bad);
        if (e >= exp_n) bad++;
        else if (mem_we !== e_we[e]) bad++;
        else if (mem_addr !== e_addr[e]) bad++;
        else if (mem_we && mem_wdata !== e_wd[e])
            bad++;
    endtask

    task automatic run_one(input string nm,
                           input bit p50,
                           input bit ep, input int ed,
                           input int ea,
                           input logic [15:0] edat,
                           input logic [15:0] eexp);
        int dn, bb, tb;
        dn = -1; bb = 0; tb = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        if (!busy) bb++;
        tr_cmp(0, tb);
        for (int e = 1; e <= 400 && dn < 0; e++) begin
            if (p50 && e == 50) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) dn = e;
            else begin
                if (!busy) bb++;
                tr_cmp(e, tb);
            end
        end
        chk({nm, " done_edge"}, dn, ed);
        chk({nm, " pass"}, pass, ep);
        chk({nm, " busy_off"}, {busy, mem_we}, 0);
        chk({nm, " fail_addr"}, fail_addr, ea);
        chk({nm, " fail_data"}, fail_data, edat);
        chk({nm, " fail_expect"}, fail_expect, eexp);
        chk({nm, " busy_run"}, bb, 0);
        chk({nm, " trace"}, tb, 0);
    endtask

    typedef struct {
        string       nm;
        int          f1a;
        logic [15:0] f1m;
        int          f0a;
        logic [15:0] f0m;
        bit          ep;
        int          ed;
        int          ea;
        logic [15:0] edat;
        logic [15:0] eexp;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int nz, dn;
        tbl[0] = '{"clean", -1, 16'h0, -1, 16'h0,
                   1, 176, 0, 16'h0, 16'h0};
        tbl[1] = '{"a5b0s1", 5, 16'h0001, -1, 16'h0,
                   0, 28, 5, 16'h0001, 16'h0000};
        tbl[2] = '{"a9b15s0", -1, 16'h0, 9, 16'h8000,
                   0, 68, 9, 16'h7FFF, 16'hFFFF};
        tbl[3] = '{"a0b15s1", 0, 16'h8000, -1, 16'h0,
                   0, 18, 0, 16'h8000, 16'h0000};
        tbl[4] = '{"a15b0s0", -1, 16'h0, 15, 16'h0001,
                   0, 80, 15, 16'hFFFE, 16'hFFFF};

        #1;
        chk("rst_ctl", {busy, done, pass, mem_we}, 0);
        chk("rst_fail", {fail_addr, fail_data,
                         fail_expect} != 0, 0);
        chk("rst_cmd", {mem_addr, mem_wdata}, 0);
        #22 rst_n = 1'b1;

        foreach (tbl[i]) begin
            f1a = tbl[i].f1a; f1m = tbl[i].f1m;
            f0a = tbl[i].f0a; f0m = tbl[i].f0m;
            build();
            run_one(tbl[i].nm, 1'b0, tbl[i].ep,
                    tbl[i].ed, tbl[i].ea,
                    tbl[i].edat, tbl[i].eexp);
            if (tbl[i].ep) begin
                nz = 0;
                for (int a = 0; a < 16; a++)
                    if (ram[a] != 16'h0) nz++;
                chk("ram_zero", nz, 0);
            end
        end

        f1a = -1; f1m = 0; f0a = -1; f0m = 0;
        build();
        run_one("restart50", 1'b1, 1, 176, 0, 0, 0);

        // Reset in the middle of a run
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("midrst_ctl",
            {busy, done, pass, mem_we}, 0);
        chk("midrst_cmd", {mem_addr, mem_wdata}, 0);
        chk("midrst_fail", {fail_addr, fail_data,
                            fail_expect} != 0, 0);
        @(negedge clk); rst_n = 1'b1;
        run_one("after_rst", 1'b0, 1, 176, 0, 0, 0);

        // start held high: back-to-back runs
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        dn = -1;
        for (int e = 1; e <= 400 && dn < 0; e++) begin
            @(posedge clk); #1;
            if (done) dn = e;
        end
        chk("held done_edge", dn, 176);
        @(posedge clk); #1;
        chk("held restart", {busy, done, mem_we,
                             mem_addr}, 7'b1010000);
        start = 1'b0;
        dn = -1;
        for (int e = 1; e <= 400 && dn < 0; e++) begin
            @(posedge clk); #1;
            if (done) dn = e;
        end
        chk("held2 done_edge", dn, 176);
        chk("held2 pass", pass, 1);

        // Random stuck-at faults against the model
        for (int r = 0; r < 6; r++) begin
            f1a = $urandom_range(0, 15);
            f0a = $urandom_range(0, 15);
            f1m = ($urandom_range(0, 2) == 0) ? 16'h0
                  : 16'(1 << $urandom_range(0, 15));
            f0m = ($urandom_range(0, 2) == 0) ? 16'h0
                  : 16'(1 << $urandom_range(0, 15));
            build();
            run_one($sformatf("rnd%0d", r), 1'b0,
                    m_pass, m_edge, m_addr,
                    m_data, m_exp);
        end

        $display("%0d/%0d checks passed",
                 passed, checks);
        $finish;
    end

endmodule
